// File: rtl/button_event_if.sv
// button_event_if: button level/tick inputs and the one-cycle event outputs.
//   level_in          debounced, synchronous button level (1 = pressed)
//   tick_in           one-cycle time-base strobe
//   press_pulse_reg   pulse on press edge
//   release_pulse_reg pulse on release edge
//   click_pulse_reg   pulse on release before the long threshold
//   long_pulse_reg    pulse when the hold reaches LONG_TICKS
//   repeat_pulse_reg  pulse every REPEAT_TICKS after a long press
//   held_reg          1 while the button is considered held
//   master: drives level/tick and observes events; slave: the event generator.
interface button_event_if;
    logic level_in;
    logic tick_in;
    logic press_pulse_reg;
    logic release_pulse_reg;
    logic click_pulse_reg;
    logic long_pulse_reg;
    logic repeat_pulse_reg;
    logic held_reg;
    modport master (
        output level_in, tick_in,
        input  press_pulse_reg, release_pulse_reg, click_pulse_reg,
               long_pulse_reg, repeat_pulse_reg, held_reg
    );
    modport slave (
        input  level_in, tick_in,
        output press_pulse_reg, release_pulse_reg, click_pulse_reg,
               long_pulse_reg, repeat_pulse_reg, held_reg
    );
endinterface

// File: rtl/button_event.sv
// button_event: turns a debounced button level into registered one-cycle
// press / release / click / long / repeat events timed by an external tick.
//   clk_in  system clock (posedge)
//   rst_in  synchronous active-high reset
//   bus     button_event_if.slave: level_in, tick_in in; event registers out
module button_event #(
    parameter int LONG_TICKS   = 500,
    parameter int REPEAT_TICKS = 100
) (
    input  logic               clk_in,
    input  logic               rst_in,
    button_event_if.slave      bus
);
    localparam int MAX_T = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
    localparam int CNT_W = $clog2((MAX_T > 2) ? MAX_T : 2);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'((REPEAT_TICKS > 0) ? REPEAT_TICKS - 1 : 0);
    localparam bit REP_EN = (REPEAT_TICKS != 0);

    typedef enum logic [1:0] {IDLE = 2'd0, PRESS = 2'd1, LONG = 2'd2} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             press_nxt, release_nxt, click_nxt, long_nxt, repeat_nxt;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state                 <= IDLE;
            cnt                   <= '0;
            bus.press_pulse_reg   <= 1'b0;
            bus.release_pulse_reg <= 1'b0;
            bus.click_pulse_reg   <= 1'b0;
            bus.long_pulse_reg    <= 1'b0;
            bus.repeat_pulse_reg  <= 1'b0;
            bus.held_reg          <= 1'b0;
        end else begin
            state                 <= state_nxt;
            cnt                   <= cnt_nxt;
            bus.press_pulse_reg   <= press_nxt;
            bus.release_pulse_reg <= release_nxt;
            bus.click_pulse_reg   <= click_nxt;
            bus.long_pulse_reg    <= long_nxt;
            bus.repeat_pulse_reg  <= repeat_nxt;
            bus.held_reg          <= (state_nxt != IDLE);
        end
    end

    // Defaults describe "back to IDLE, counter cleared, no events", which is
    // also what the unused state code falls into.
    always_comb begin
        state_nxt   = IDLE;
        cnt_nxt     = '0;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        click_nxt   = 1'b0;
        long_nxt    = 1'b0;
        repeat_nxt  = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = bus.level_in ? PRESS : IDLE;
                press_nxt = bus.level_in;
            end
            PRESS: begin
                // Release is checked first so it wins over a coincident tick.
                if (!bus.level_in) begin
                    release_nxt = 1'b1;
                    click_nxt   = 1'b1;
                end else if (bus.tick_in && cnt == LONG_LAST) begin
                    state_nxt = LONG;
                    long_nxt  = 1'b1;
                end else begin
                    state_nxt = PRESS;
                    cnt_nxt   = bus.tick_in ? cnt + 1'b1 : cnt;
                end
            end
            LONG: begin
                if (!bus.level_in) begin
                    release_nxt = 1'b1;
                end else begin
                    state_nxt = LONG;
                    if (REP_EN && bus.tick_in) begin
                        repeat_nxt = (cnt == REP_LAST);
                        cnt_nxt    = (cnt == REP_LAST) ? '0 : cnt + 1'b1;
                    end else begin
                        cnt_nxt = cnt;
                    end
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_button_event.sv
// tb_button_event: scoreboard bench for button_event with LONG_TICKS=4 and
// REPEAT_TICKS=2 (dut_a) / REPEAT_TICKS=0 (dut_b), both fed the same stimulus.
module tb_button_event;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic level = 1'b0;
    logic tick = 1'b0;

    always #5 clk = ~clk;

    button_event_if bus_a();
    button_event_if bus_b();

    assign bus_a.level_in = level;
    assign bus_a.tick_in  = tick;
    assign bus_b.level_in = level;
    assign bus_b.tick_in  = tick;

    button_event #(.LONG_TICKS(4), .REPEAT_TICKS(2)) dut_a (.clk_in(clk), .rst_in(rst), .bus(bus_a));
    button_event #(.LONG_TICKS(4), .REPEAT_TICKS(0)) dut_b (.clk_in(clk), .rst_in(rst), .bus(bus_b));

    // Output vector bit order: press, release, click, long, repeat, held.
    wire [5:0] out_a = {bus_a.press_pulse_reg, bus_a.release_pulse_reg, bus_a.click_pulse_reg,
                        bus_a.long_pulse_reg, bus_a.repeat_pulse_reg, bus_a.held_reg};
    wire [5:0] out_b = {bus_b.press_pulse_reg, bus_b.release_pulse_reg, bus_b.click_pulse_reg,
                        bus_b.long_pulse_reg, bus_b.repeat_pulse_reg, bus_b.held_reg};

    typedef struct packed {
        logic [5:0] a;
        logic [5:0] b;
    } exp_t;

    exp_t       q[$];
    int         n_vec = 0;
    int         n_err = 0;
    logic [5:0] obs_a, obs_b;

    // Behavioural model: ticks counted since the press, events derived from
    // the total rather than from a wrapping counter.
    bit mh[2];
    int mt[2];

    function automatic logic [5:0] model(input int i, input logic r, input logic l, input logic t);
        int         rt;
        logic [5:0] o;
        rt = (i == 0) ? 2 : 0;
        o  = 6'b0;
        if (r) begin
            mh[i] = 1'b0;
            mt[i] = 0;
        end else if (!mh[i]) begin
            if (l) begin
                mh[i] = 1'b1;
                mt[i] = 0;
                o     = 6'b100001;
            end
        end else if (!l) begin
            mh[i] = 1'b0;
            o     = {1'b0, 1'b1, (mt[i] < 4), 3'b000};
        end else begin
            if (t) begin
                mt[i] = mt[i] + 1;
                o[2]  = (mt[i] == 4);
                o[1]  = (rt != 0) && (mt[i] > 4) && ((mt[i] - 4) % rt == 0);
            end
            o[0] = 1'b1;
        end
        return o;
    endfunction

    task automatic step(input logic r, input logic l, input logic t);
        exp_t e;
        rst   = r;
        level = l;
        tick  = t;
        q.push_back({model(0, r, l, t), model(1, r, l, t)});
        @(posedge clk);
        @(negedge clk);
        obs_a = out_a;
        obs_b = out_b;
        e = q.pop_front();
        n_vec++;
        if (obs_a !== e.a) begin
            n_err++;
            $display("FAIL sb_rep2 t=%0t got=%b exp=%b", $time, obs_a, e.a);
        end
        n_vec++;
        if (obs_b !== e.b) begin
            n_err++;
            $display("FAIL sb_rep0 t=%0t got=%b exp=%b", $time, obs_b, e.b);
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b1, 1'b1);
            n_vec++;
            if (obs_a !== 6'b0) begin
                n_err++;
                $display("FAIL reset_hold got=%b exp=%b", obs_a, 6'b0);
            end
        end
        step(1'b0, 1'b1, 1'b0);
        n_vec++;
        if (obs_a !== 6'b100001) begin
            n_err++;
            $display("FAIL reset_release_press got=%b exp=%b", obs_a, 6'b100001);
        end
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_short_click();
        int c[6];
        for (int j = 0; j < 6; j++) c[j] = 0;
        step(1'b0, 1'b1, 1'b0);
        for (int j = 0; j < 6; j++) c[j] += obs_a[j];
        for (int k = 0; k < 9; k++) begin
            step(1'b0, 1'b1, (k % 3 == 2));
            for (int j = 1; j < 6; j++) c[j] += obs_a[j];
        end
        step(1'b0, 1'b0, 1'b0);
        for (int j = 1; j < 6; j++) c[j] += obs_a[j];
        n_vec++;
        if ({c[5], c[4], c[3], c[2], c[1]} !== {32'd1, 32'd1, 32'd1, 32'd0, 32'd0}) begin
            n_err++;
            $display("FAIL short_click counts press/rel/click/long/rep got=%0d/%0d/%0d/%0d/%0d exp=1/1/1/0/0",
                     c[5], c[4], c[3], c[2], c[1]);
        end
    endtask

    task automatic test_long_repeat();
        logic [11:0] pm, lm, rm;
        pm = '0;
        lm = '0;
        rm = '0;
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 1'b1, 1'b1);
            pm[k] = obs_a[5];
            lm[k] = obs_a[2];
            rm[k] = obs_a[1];
        end
        n_vec++;
        if ({pm, lm, rm} !== {12'h001, 12'h010, 12'h540}) begin
            n_err++;
            $display("FAIL long_repeat_timing press/long/rep got=%h/%h/%h exp=001/010/540", pm, lm, rm);
        end
        step(1'b0, 1'b0, 1'b1);
        n_vec++;
        if (obs_a[4:3] !== 2'b10) begin
            n_err++;
            $display("FAIL long_release rel/click got=%b exp=10", obs_a[4:3]);
        end
    endtask

    task automatic test_collision();
        step(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        n_vec++;
        if (obs_a !== 6'b011000) begin
            n_err++;
            $display("FAIL collision got=%b exp=%b", obs_a, 6'b011000);
        end
        step(1'b0, 1'b0, 1'b1);
        n_vec++;
        if (obs_a !== 6'b0) begin
            n_err++;
            $display("FAIL collision_idle got=%b exp=%b", obs_a, 6'b0);
        end
    endtask

    task automatic test_repeat_zero();
        int nl, nr, nh;
        nl = 0;
        nr = 0;
        nh = 0;
        step(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 1'b1, 1'b1);
            nl += obs_b[2];
            nr += obs_b[1];
            nh += obs_b[0];
        end
        n_vec++;
        if (nl !== 1 || nr !== 0 || nh !== 20) begin
            n_err++;
            $display("FAIL repeat_zero long/rep/held got=%0d/%0d/%0d exp=1/0/20", nl, nr, nh);
        end
        step(1'b0, 1'b0, 1'b0);
        n_vec++;
        if (obs_b !== 6'b010000) begin
            n_err++;
            $display("FAIL repeat_zero_release got=%b exp=%b", obs_b, 6'b010000);
        end
    endtask

    task automatic test_reset_mid_hold();
        int nl;
        step(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        n_vec++;
        if (obs_a !== 6'b0) begin
            n_err++;
            $display("FAIL reset_mid_hold got=%b exp=%b", obs_a, 6'b0);
        end
        step(1'b0, 1'b1, 1'b1);
        n_vec++;
        if (obs_a !== 6'b100001) begin
            n_err++;
            $display("FAIL repress got=%b exp=%b", obs_a, 6'b100001);
        end
        nl = 0;
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, 1'b1);
            nl += obs_a[2];
        end
        step(1'b0, 1'b1, 1'b1);
        n_vec++;
        if (nl !== 0 || obs_a[2] !== 1'b1) begin
            n_err++;
            $display("FAIL repress_long early=%0d last=%b exp=0/1", nl, obs_a[2]);
        end
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [5:0] exp_v[4];
        exp_v[0] = 6'b100001;
        exp_v[1] = 6'b011000;
        exp_v[2] = 6'b100001;
        exp_v[3] = 6'b011000;
        for (int k = 0; k < 4; k++) begin
            step(1'b0, (k % 2 == 0), 1'b0);
            n_vec++;
            if (obs_a !== exp_v[k]) begin
                n_err++;
                $display("FAIL back_to_back[%0d] got=%b exp=%b", k, obs_a, exp_v[k]);
            end
        end
    endtask

    initial begin
        mh[0] = 1'b0;
        mh[1] = 1'b0;
        mt[0] = 0;
        mt[1] = 0;
        @(negedge clk);
        test_reset();
        test_short_click();
        test_long_repeat();
        test_collision();
        test_repeat_zero();
        test_reset_mid_hold();
        test_back_to_back();
        n_vec++;
        if (q.size() !== 0) begin
            n_err++;
            $display("FAIL scoreboard_drain left=%0d exp=0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
